// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-cache arbiter: read-owner tag and debug-lock states.
package dmem_arbiter_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } MemOwner;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    LOCK_PEND = 2'd1,
    LOCKED    = 2'd2
  } LockState;

  localparam int          STARVE_W   = 4;
  localparam logic [3:0]  STARVE_MAX = 4'd15;

endpackage

// File: rtl/dmem_lock_fsm.sv
// Debug lock state machine: holds the CPU off the cache once no CPU read remains outstanding.
module dmem_lock_fsm
  import dmem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic lock,
  input  logic cpu_rd_inflight,
  output logic cpu_block,
  output logic locked
);

  LockState state, state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= UNLOCKED;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    cpu_block  = 1'b0;
    locked     = 1'b0;
    case (state)
      UNLOCKED: begin
        if (lock) state_next = LOCK_PEND;
      end
      LOCK_PEND: begin
        cpu_block = 1'b1;
        if (!lock)                 state_next = UNLOCKED;
        else if (!cpu_rd_inflight) state_next = LOCKED;
      end
      LOCKED: begin
        cpu_block = 1'b1;
        locked    = 1'b1;
        if (!lock) state_next = UNLOCKED;
      end
      default: state_next = UNLOCKED;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data cache (CPU execute stage and debug/loader port).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_lock,
  output logic              dbg_locked,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
    return (v == STARVE_MAX) ? v : v + 1'b1;
  endfunction

  logic [STARVE_W-1:0] starve_cnt;
  logic                cpu_block;
  logic                rd_issue;
  logic                cpu_rd_inflight;
  logic                rd_pend_p1;
  MemOwner             rd_owner_p1;
  logic [DATA_W-1:0]   cpu_rdata_p1;
  logic [DATA_W-1:0]   dbg_rdata_p1;

  // Issue stage: pick one winner and drive the cache port.
  assign dbg_gnt   = dbg_req & (cpu_block | ~cpu_req | (starve_cnt >= LIMIT));
  assign cpu_gnt   = cpu_req & ~cpu_block & ~dbg_gnt;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (dbg_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (cpu_gnt) begin
      mem_en = 1'b1;
      mem_we = cpu_we;
    end
  end

  assign rd_issue = mem_en & ~mem_we;
  // A read returning this cycle is finished once the cycle ends; only a CPU read
  // issued now would still be outstanding when the lock takes effect.
  assign cpu_rd_inflight = rd_issue & cpu_gnt;

  dmem_lock_fsm u_lock_fsm (
    .clk             (clk),
    .rst_n           (rst_n),
    .lock            (dbg_lock),
    .cpu_rd_inflight (cpu_rd_inflight),
    .cpu_block       (cpu_block),
    .locked          (dbg_locked)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt  <= '0;
      rd_pend_p1  <= 1'b0;
      rd_owner_p1 <= OWN_CPU;
    end else begin
      starve_cnt <= (dbg_req & ~dbg_gnt) ? sat_inc(starve_cnt) : '0;
      rd_pend_p1 <= rd_issue;
      if (rd_issue) rd_owner_p1 <= dbg_gnt ? OWN_DBG : OWN_CPU;
    end
  end

  // Return stage: cache data arrives one cycle after issue and is steered to its owner.
  assign cpu_rvalid = rd_pend_p1 & (rd_owner_p1 == OWN_CPU);
  assign dbg_rvalid = rd_pend_p1 & (rd_owner_p1 == OWN_DBG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_p1 <= '0;
      dbg_rdata_p1 <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_p1 <= mem_rdata;
      if (dbg_rvalid) dbg_rdata_p1 <= mem_rdata;
    end
  end

  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_p1;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_rdata_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 1-cycle-latency cache model behind the port.
module tb_dmem_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dbg_req, dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt, dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_lock, dbg_locked;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] mem [32];

  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_lock(dbg_lock), .dbg_locked(dbg_locked),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [ADDR_W-1:0] pre_a [4];
    logic [DATA_W-1:0] pre_d [4];
    pre_a = '{5'd1, 5'd2, 5'd3, 5'd4};
    pre_d = '{32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF, 32'h4444_4444};

    rst_n = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    dbg_lock = 0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_dbg_rvalid", dbg_rvalid, 0);
    chk("rst_dbg_locked", dbg_locked, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    chk("rst_mem_en", mem_en, 0);
    tick(); tick();
    rst_n = 1'b1;

    // Preload through the debug port.
    for (int i = 0; i < 4; i++) begin
      tick();
      dbg_req = 1; dbg_we = 1; dbg_addr = pre_a[i]; dbg_wdata = pre_d[i];
    end
    tick();
    dbg_req = 0; dbg_we = 0;

    // CPU-only read of addr 3.
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd3;
    #3;
    chk("rd_cpu_gnt", cpu_gnt, 1);
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_addr", mem_addr, 3);
    chk("rd_cpu_stall", cpu_stall, 0);
    tick();
    cpu_req = 0;
    #3;
    chk("rd_cpu_rvalid", cpu_rvalid, 1);
    chk("rd_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("rd_dbg_rvalid", dbg_rvalid, 0);
    tick();
    #3;
    chk("rd_rvalid_pulse", cpu_rvalid, 0);
    chk("rd_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

    // Debug-only write while unlocked.
    tick();
    dbg_req = 1; dbg_we = 1; dbg_addr = 5'd5; dbg_wdata = 32'hA5A5_0005;
    #3;
    chk("dw_dbg_gnt", dbg_gnt, 1);
    chk("dw_mem_we", mem_we, 1);
    chk("dw_mem_addr", mem_addr, 5);
    chk("dw_mem_wdata", mem_wdata, 32'hA5A5_0005);
    tick();
    dbg_req = 0; dbg_we = 0;
    #3;
    chk("dw_starve", dut.starve_cnt, 0);
    chk("dw_no_rvalid", dbg_rvalid, 0);

    // Contention: CPU wins four cycles, debug wins the fifth.
    tick();
    cpu_req = 1; cpu_we = 1; cpu_addr = 5'd10; cpu_wdata = 32'h0000_00AA;
    dbg_req = 1; dbg_we = 1; dbg_addr = 5'd11; dbg_wdata = 32'h0000_00BB;
    for (int k = 0; k < 6; k++) begin
      #3;
      chk($sformatf("ct_cpu_gnt%0d", k), cpu_gnt, (k == 4) ? 0 : 1);
      chk($sformatf("ct_dbg_gnt%0d", k), dbg_gnt, (k == 4) ? 1 : 0);
      chk($sformatf("ct_stall%0d", k), cpu_stall, (k == 4) ? 1 : 0);
      if (k == 4) chk("ct_starve_at_limit", dut.starve_cnt, 4);
      if (k == 5) chk("ct_starve_cleared", dut.starve_cnt, 0);
      tick();
    end
    cpu_req = 0; cpu_we = 0; dbg_req = 0; dbg_we = 0;

    // Interleaved reads: CPU addr 1 then debug addr 2.
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd1;
    #3;
    chk("il_cpu_gnt", cpu_gnt, 1);
    tick();
    cpu_req = 0;
    dbg_req = 1; dbg_we = 0; dbg_addr = 5'd2;
    #3;
    chk("il_dbg_gnt", dbg_gnt, 1);
    chk("il_cpu_rvalid", cpu_rvalid, 1);
    chk("il_cpu_rdata", cpu_rdata, 32'h1111_1111);
    chk("il_dbg_rvalid0", dbg_rvalid, 0);
    tick();
    dbg_req = 0;
    #3;
    chk("il_dbg_rvalid", dbg_rvalid, 1);
    chk("il_dbg_rdata", dbg_rdata, 32'h2222_2222);
    chk("il_cpu_rvalid0", cpu_rvalid, 0);
    chk("il_cpu_rdata_hold", cpu_rdata, 32'h1111_1111);

    // Lock requested while a CPU read is being granted.
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd4;
    dbg_lock = 1;
    #3;
    chk("lk_c0_cpu_gnt", cpu_gnt, 1);
    chk("lk_c0_locked", dbg_locked, 0);
    tick();
    #3;
    chk("lk_c1_rvalid", cpu_rvalid, 1);
    chk("lk_c1_rdata", cpu_rdata, 32'h4444_4444);
    chk("lk_c1_cpu_gnt", cpu_gnt, 0);
    chk("lk_c1_stall", cpu_stall, 1);
    chk("lk_c1_locked", dbg_locked, 0);
    tick();
    dbg_req = 1; dbg_we = 1; dbg_addr = 5'd7; dbg_wdata = 32'h1234_5678;
    #3;
    chk("lk_c2_locked", dbg_locked, 1);
    chk("lk_c2_dbg_gnt", dbg_gnt, 1);
    chk("lk_c2_cpu_gnt", cpu_gnt, 0);
    chk("lk_c2_mem_we", mem_we, 1);
    chk("lk_c2_mem_addr", mem_addr, 7);
    tick();
    dbg_req = 0; dbg_we = 0; dbg_lock = 0; cpu_addr = 5'd7;
    #3;
    chk("lk_c3_locked", dbg_locked, 1);
    chk("lk_c3_cpu_gnt", cpu_gnt, 0);
    tick();
    #3;
    chk("lk_c4_locked", dbg_locked, 0);
    chk("lk_c4_cpu_gnt", cpu_gnt, 1);
    chk("lk_c4_mem_addr", mem_addr, 7);
    tick();
    cpu_req = 0;
    #3;
    chk("lk_c5_rvalid", cpu_rvalid, 1);
    chk("lk_c5_rdata", cpu_rdata, 32'h1234_5678);

    // Reset while a CPU read is returning.
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd3;
    #3;
    chk("rr_cpu_gnt", cpu_gnt, 1);
    tick();
    chk("rr_rvalid_before", cpu_rvalid, 1);
    cpu_req = 0;
    rst_n = 1'b0;
    #1;
    chk("rr_rvalid_async", cpu_rvalid, 0);
    chk("rr_rdata_async", cpu_rdata, 0);
    chk("rr_locked_async", dbg_locked, 0);
    chk("rr_mem_en_async", mem_en, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    #3;
    chk("rr_no_stale_cpu", cpu_rvalid, 0);
    chk("rr_no_stale_dbg", dbg_rvalid, 0);
    chk("rr_starve", dut.starve_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data cache between two requesters: the CPU execute stage (loads/stores) and a debug/loader port (program and data upload, memory inspection).
- Accepts at most one access per cycle and drives the cache port. Routes the 1-cycle-latency read data back to the requester that issued the read.
- Generates the CPU stall. Supports a debug lock that holds the CPU off the memory entirely.

Parameters:
- ADDR_W, 5, cache word-address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive cycles the debug port may be refused before it wins priority (1..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes decode/execute
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata  same as the CPU set, for the debug port
- dbg_lock  in  1  request exclusive debug ownership
- dbg_locked  out  1  lock in effect; the CPU is refused
- mem_en  out  1  cache access strobe
- mem_we  out  1  cache write enable
- mem_addr  out  ADDR_W  cache address
- mem_wdata  out  DATA_W  cache write data
- mem_rdata  in  DATA_W  cache read data, valid the cycle after mem_en & ~mem_we

Behaviour:
Interface and reset
- Single clock domain, posedge clk. rst_n is asynchronous, active-low.
- Reset values:
  - lock FSM in UNLOCKED
  - starve_cnt = 0
  - rd_pend = 0, rd_owner = CPU
  - cpu_rvalid, dbg_rvalid, dbg_locked = 0
  - cpu_rdata, dbg_rdata = 0

Grant logic (combinational, single winner per cycle)
- In LOCKED or LOCK_PEND, the CPU is never granted.
- Otherwise the debug port wins when dbg_req & (~cpu_req | starve_cnt >= STARVE_LIMIT). The CPU wins in all other cases where cpu_req = 1.
- The winner's we/addr/wdata drive mem_*, with mem_en = 1. With no winner: mem_en = 0, mem_we = 0, and mem_addr/mem_wdata hold the CPU values.
- A grant completes the request handshake in that same cycle. A write needs no further response.

Read return
- On a granted read, the block registers rd_pend = 1 and rd_owner = winner.
- In the next cycle it asserts the owner's rvalid for exactly 1 cycle, with rdata = mem_rdata. That rdata is registered and held until the next read by the same owner.
- Back-to-back reads (from either owner) are legal: one in flight per cycle, fully pipelined.

Starvation counter
- Increments (saturating at 15) when dbg_req = 1 and dbg_gnt = 0.
- Clears to 0 on dbg_gnt, or when dbg_req = 0.

Lock FSM
- UNLOCKED -> LOCK_PEND on dbg_lock = 1.
- LOCK_PEND -> LOCKED when no CPU read is in flight (rd_pend = 0 or rd_owner = DBG). The transition happens that same cycle if the check is already satisfied.
- LOCKED -> UNLOCKED on dbg_lock = 0.
- LOCK_PEND -> UNLOCKED if dbg_lock drops before the lock is reached.
- dbg_locked = 1 only in LOCKED.
- The CPU stalls from the first LOCK_PEND cycle.

Boundary conditions
- Both ports request in the same cycle with starve_cnt < STARVE_LIMIT: the CPU wins.
- Both ports request at the limit: the debug port wins and the counter clears.
- A write grant and a read return in the same cycle are independent; both happen.
- Reset mid-read: the pending rvalid is dropped and no response is issued after reset.
- Requests with req = 0 ignore we/addr/wdata.

Decomposition:
- Utilities package holds:
  - typedef enum {OWN_CPU, OWN_DBG} MemOwner
  - typedef enum {UNLOCKED, LOCK_PEND, LOCKED} LockState
- Natural sub-module: dmem_lock_fsm (lock state plus the in-flight check).
- Grant mux and read return stay in the top module.

Test Plan:
- CPU-only read: cpu_req=1, cpu_we=0, addr=3, memory[3]=0xDEADBEEF -> cpu_gnt same cycle; cpu_rvalid=1 next cycle with cpu_rdata=0xDEADBEEF; dbg_rvalid stays 0.
- Contention with STARVE_LIMIT=4: both ports request continuously -> CPU granted cycles 0-3; debug granted cycle 4; CPU cpu_stall=1 in cycle 4 only; counter returns to 0.
- Interleaved reads: CPU read addr 1 then debug read addr 2 in consecutive cycles -> cpu_rvalid in cycle 1 with mem[1]; dbg_rvalid in cycle 2 with mem[2]; no cross-routing.
- Lock with CPU read in flight: CPU read granted cycle 0, dbg_lock=1 in cycle 0 -> LOCK_PEND in cycle 1 (CPU read returns); dbg_locked=1 from cycle 2; CPU requests refused; debug write 0x12345678 to addr 7 granted; after dbg_lock drops, a CPU read of addr 7 returns 0x12345678.
- Reset mid-read: read granted, rst_n=0 in the next cycle -> cpu_rvalid=0 and all outputs at reset values immediately (asynchronously), with no stale rvalid after rst_n rises.
- Debug-only write while unlocked: dbg_req=1, dbg_we=1, cpu_req=0 -> dbg_gnt=1, mem_we=1 same cycle; starve_cnt stays 0.
